md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  EX-stage multiply/divide unit with HI/LO registers; consumes GRF RsData/RtData operands.
//  Executes mult, multu, div, divu over a fixed multi-cycle latency and handles mthi/mtlo.
//  Drives HI/LO back into the EX result mux for mfhi/mflo.
//  Busy, together with Start, feeds the hazard unit to stall later MD instructions.
// PARAMETERS
//  MULT_CYCLES  5   cycles Busy stays high for mult/multu (>=1)
//  DIV_CYCLES   10  cycles Busy stays high for div/divu (>=1)
// PORTS
//  clk     in   1   clock, all state updates on posedge
//  Reset   in   1   synchronous, active-high reset
//  Start   in   1   1-cycle launch strobe for the op on MDOp
//  MDOp    in   3   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved (no-op)
//  RsData  in   32  operand A (dividend / multiplicand / mthi-mtlo source)
//  RtData  in   32  operand B (divisor / multiplier)
//  Busy    out  1   high while a mult/div is in progress
//  HI      out  32  HI register (product[63:32] / remainder)
//  LO      out  32  LO register (product[31:0] / quotient)
// BEHAVIOUR
//  Reset (posedge clk, Reset=1): HI=0, LO=0, Busy=0, counter=0, state IDLE; in-flight op discarded.
//  FSM: IDLE, BUSY.
//  IDLE + Start + MDOp in {0..3}:
//   - latch RsData, RtData, MDOp
//   - load counter = MULT_CYCLES (ops 0/1) or DIV_CYCLES (ops 2/3)
//   - go to BUSY; Busy=1 from the next cycle.
//  BUSY: counter decrements each cycle. On the edge where counter goes 1->0:
//   - HI/LO take the result; Busy=0; state IDLE.
//   - So Busy is high for exactly N cycles; new HI/LO are visible in the first cycle Busy=0.
//  IDLE + Start + MDOp=4 (mthi): HI<=RsData at the same edge; Busy stays 0.
//  IDLE + Start + MDOp=5 (mtlo): LO<=RsData at the same edge; Busy stays 0.
//  Start + MDOp 6/7: no effect.
//  Start while BUSY (any MDOp): ignored. Latched operands, counter and HI/LO are unaffected.
//   The hazard unit must stall instead; the unit does not queue ops.
//  Arithmetic:
//   - mult: signed 32x32->64. multu: unsigned 32x32->64. {HI,LO}=product.
//   - div: signed. LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
//   - divu: unsigned; LO=quotient, HI=remainder.
//   - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
//   - Divisor 0 (div/divu): full latency runs, Busy behaves normally, HI/LO left unchanged.
//  Operands are sampled only at Start. Changes on RsData/RtData during BUSY have no effect.
//  Reset asserted mid-BUSY: immediate return to IDLE, Busy=0 next cycle, HI=LO=0.
//  HI/LO change only on a completed mult/div, mthi, mtlo or Reset; otherwise they hold.
// TESTING
//  1 Reset, then idle 3 cycles -> HI=0, LO=0, Busy=0 throughout.
//  2 mult Rs=0xFFFFFFFE, Rt=3 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA;
//    multu same operands -> HI=0x00000002, LO=0xFFFFFFFA.
//  3 div Rs=0xFFFFFFF9 (-7), Rt=2 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF;
//    divu Rs=7, Rt=0 -> HI/LO keep prior values after 10 cycles.
//  4 mthi 0x12345678 then mtlo 0x9ABCDEF0 on consecutive cycles -> HI/LO updated the next edge, Busy never set.
//  5 mult 2x3, Start+mtlo 0xDEAD at cycle 2 of Busy -> mtlo ignored; after completion HI=0, LO=6.
//  6 div started, Reset at cycle 4 of Busy -> next cycle Busy=0, HI=LO=0; no later update.

Source files
------------

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit with HI/LO registers.
// A mult/div holds Busy for a fixed number of cycles, then commits its result to HI/LO.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      op_q;
    logic [31:0]     a_q;
    logic [31:0]     b_q;
    logic [31:0]     hi_q;
    logic [31:0]     lo_q;
    logic            busy_q;

    logic [63:0]     prodS;
    logic [63:0]     prodU;
    logic [31:0]     hi_d;
    logic [31:0]     lo_d;
    logic            commit_d;

    // Result of the latched op, committed when the countdown expires.
    always_comb begin
        prodS    = 64'($signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q}));
        prodU    = {32'd0, a_q} * {32'd0, b_q};
        hi_d     = hi_q;
        lo_d     = lo_q;
        commit_d = 1'b1;
        case (op_q)
            2'd0: {hi_d, lo_d} = prodS;
            2'd1: {hi_d, lo_d} = prodU;
            2'd2: begin
                if (b_q == 32'd0) begin
                    commit_d = 1'b0;
                end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
                    // Signed overflow case: quotient wraps, remainder is zero.
                    lo_d = 32'h8000_0000;
                    hi_d = 32'd0;
                end else begin
                    lo_d = 32'($signed(a_q) / $signed(b_q));
                    hi_d = 32'($signed(a_q) % $signed(b_q));
                end
            end
            default: begin
                if (b_q == 32'd0) begin
                    commit_d = 1'b0;
                end else begin
                    lo_d = a_q / b_q;
                    hi_d = a_q % b_q;
                end
            end
        endcase
    end

    // Control FSM; Start is ignored while busy, the hazard unit stalls instead.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        case (MDOp)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                op_q    <= MDOp[1:0];
                                a_q     <= RsData;
                                b_q     <= RtData;
                                cnt_q   <= MDOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                                busy_q  <= 1'b1;
                                state_q <= BUSY;
                            end
                            3'd4:    hi_q <= RsData;
                            3'd5:    lo_q <= RsData;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        if (commit_d) begin
                            hi_q <= hi_d;
                            lo_q <= lo_d;
                        end
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit: mult/div results and latency, mthi/mtlo,
// Start-while-busy rejection and reset during an operation.
module tb_md_unit;

    logic        clk;
    logic        Reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int passCount  = 0;
    int checkCount = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .Reset  (Reset),
        .Start  (Start),
        .MDOp   (MDOp),
        .RsData (RsData),
        .RtData (RtData),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle Start for op with the given operands.
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start  = 1'b1;
        MDOp   = op;
        RsData = a;
        RtData = b;
        tick();
        Start  = 1'b0;
    endtask

    // Count cycles until Busy falls, scrambling operand inputs meanwhile.
    task automatic wait_done(output int n);
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            RsData = $urandom;
            RtData = $urandom;
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; MDOp = 3'd0; RsData = 32'd0; RtData = 32'd0;
        tick(); tick();
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkCount++;
            if (HI !== 32'd0 || LO !== 32'd0 || Busy !== 1'b0)
                $display("[TB] FAIL reset_idle cycle %0d: HI=%h LO=%h Busy=%b, want 0/0/0", i, HI, LO, Busy);
            else passCount++;
        end
    endtask

    task automatic test_mult();
        int n;
        launch(3'd0, 32'hFFFF_FFFE, 32'd3);
        checkCount++;
        if (Busy !== 1'b1) $display("[TB] FAIL mult_busy_start: Busy=%b want 1", Busy);
        else passCount++;
        wait_done(n);
        checkCount++;
        if (n !== 5 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA)
            $display("[TB] FAIL mult: cycles=%0d HI=%h LO=%h, want 5 ffffffff fffffffa", n, HI, LO);
        else passCount++;

        launch(3'd1, 32'hFFFF_FFFE, 32'd3);
        wait_done(n);
        checkCount++;
        if (n !== 5 || HI !== 32'h0000_0002 || LO !== 32'hFFFF_FFFA)
            $display("[TB] FAIL multu: cycles=%0d HI=%h LO=%h, want 5 00000002 fffffffa", n, HI, LO);
        else passCount++;
    endtask

    task automatic test_div();
        int n;
        launch(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        checkCount++;
        if (n !== 10 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD)
            $display("[TB] FAIL div_neg: cycles=%0d HI=%h LO=%h, want 10 ffffffff fffffffd", n, HI, LO);
        else passCount++;

        launch(3'd3, 32'd7, 32'd0);
        wait_done(n);
        checkCount++;
        if (n !== 10 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD)
            $display("[TB] FAIL divu_by_zero: cycles=%0d HI=%h LO=%h, want 10 ffffffff fffffffd", n, HI, LO);
        else passCount++;

        launch(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        checkCount++;
        if (HI !== 32'd0 || LO !== 32'h8000_0000)
            $display("[TB] FAIL div_overflow: HI=%h LO=%h, want 00000000 80000000", HI, LO);
        else passCount++;

        launch(3'd2, 32'd7, 32'hFFFF_FFFE);
        wait_done(n);
        checkCount++;
        if (HI !== 32'd1 || LO !== 32'hFFFF_FFFD)
            $display("[TB] FAIL div_neg_divisor: HI=%h LO=%h, want 00000001 fffffffd", HI, LO);
        else passCount++;

        launch(3'd3, 32'hFFFF_FFFF, 32'd7);
        wait_done(n);
        checkCount++;
        if (HI !== 32'd3 || LO !== 32'h2492_4924)
            $display("[TB] FAIL divu: HI=%h LO=%h, want 00000003 24924924", HI, LO);
        else passCount++;
    endtask

    task automatic test_mthi_mtlo();
        Start = 1'b1; MDOp = 3'd4; RsData = 32'h1234_5678;
        tick();
        checkCount++;
        if (HI !== 32'h1234_5678 || Busy !== 1'b0)
            $display("[TB] FAIL mthi: HI=%h Busy=%b, want 12345678 0", HI, Busy);
        else passCount++;
        MDOp = 3'd5; RsData = 32'h9ABC_DEF0;
        tick();
        checkCount++;
        if (LO !== 32'h9ABC_DEF0 || HI !== 32'h1234_5678 || Busy !== 1'b0)
            $display("[TB] FAIL mtlo: HI=%h LO=%h Busy=%b, want 12345678 9abcdef0 0", HI, LO, Busy);
        else passCount++;
        MDOp = 3'd6; RsData = 32'h5555_5555;
        tick();
        MDOp = 3'd7;
        tick();
        Start = 1'b0;
        checkCount++;
        if (HI !== 32'h1234_5678 || LO !== 32'h9ABC_DEF0 || Busy !== 1'b0)
            $display("[TB] FAIL reserved_op: HI=%h LO=%h Busy=%b, want 12345678 9abcdef0 0", HI, LO, Busy);
        else passCount++;
    endtask

    task automatic test_start_while_busy();
        int n;
        launch(3'd0, 32'd2, 32'd3);
        tick();
        Start = 1'b1; MDOp = 3'd5; RsData = 32'h0000_DEAD;
        tick();
        Start = 1'b0;
        checkCount++;
        if (LO !== 32'h9ABC_DEF0 || Busy !== 1'b1)
            $display("[TB] FAIL mtlo_while_busy: LO=%h Busy=%b, want 9abcdef0 1", LO, Busy);
        else passCount++;
        wait_done(n);
        checkCount++;
        if (n !== 3 || HI !== 32'd0 || LO !== 32'd6)
            $display("[TB] FAIL mult_after_ignored: remaining=%0d HI=%h LO=%h, want 3 00000000 00000006", n, HI, LO);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        int n;
        launch(3'd1, 32'd100, 32'd200);
        wait_done(n);
        launch(3'd3, 32'd100, 32'd7);
        wait_done(n);
        checkCount++;
        if (n !== 10 || HI !== 32'd2 || LO !== 32'd14)
            $display("[TB] FAIL back_to_back: cycles=%0d HI=%h LO=%h, want 10 00000002 0000000e", n, HI, LO);
        else passCount++;
    endtask

    task automatic test_reset_mid_busy();
        bit sawChange;
        launch(3'd2, 32'd100, 32'd7);
        tick(); tick(); tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checkCount++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
            $display("[TB] FAIL reset_mid_busy: Busy=%b HI=%h LO=%h, want 0 0 0", Busy, HI, LO);
        else passCount++;
        sawChange = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) sawChange = 1'b1;
        end
        checkCount++;
        if (sawChange)
            $display("[TB] FAIL after_reset_hold: Busy=%b HI=%h LO=%h, want 0 0 0 throughout", Busy, HI, LO);
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
